// File: rtl/md_unit_pkg.sv
// md_defs: shared definitions for the E-stage multiply/divide unit.
//   - md_op encodings driven by the E-stage decoder
//   - FSM state encodings for md_unit
//   - default busy-cycle counts for multiply and divide
//   - small decode helpers used by the datapath and the control FSM
package md_defs;

    // Operation encodings; 3'd7 is reserved and behaves like MD_NONE.
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // FSM state encodings.
    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_RUN  = 1'b1;

    // Default latencies in cycles of busy.
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // True for operations that treat their operands as two's complement.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Two's-complement negation of a 32-bit value.
    function automatic logic [31:0] md_neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: purely combinational multiply/divide datapath.
//   md_op    in  : operation select (md_defs encodings)
//   rs_val   in  : first operand (multiplicand / dividend)
//   rt_val   in  : second operand (multiplier / divisor)
//   result   out : {hi, lo}; product for mult, {remainder, quotient} for div
//   div_zero out : divide operation with rt_val == 0 (result is meaningless)
// Signed operations are done on magnitudes and the sign is restored after,
// which makes 0x80000000 / -1 come out as lo=0x80000000, hi=0 with no
// special case, and keeps truncation toward zero with the remainder
// following the dividend's sign.
module md_calc
    import md_defs::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        sgn_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] divisor_s;
    logic [63:0] prod_mag_s;
    logic [31:0] quot_mag_s;
    logic [31:0] rem_mag_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Magnitude/sign datapath shared by multiply and divide.
    always_comb begin
        sgn_s      = md_is_signed(md_op);
        a_neg_s    = sgn_s & rs_val[31];
        b_neg_s    = sgn_s & rt_val[31];
        a_mag_s    = a_neg_s ? md_neg32(rs_val) : rs_val;
        b_mag_s    = b_neg_s ? md_neg32(rt_val) : rt_val;
        // Substitute a divisor of 1 so the divider never sees zero.
        divisor_s  = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        prod_mag_s = {32'd0, a_mag_s} * {32'd0, b_mag_s};
        quot_mag_s = a_mag_s / divisor_s;
        rem_mag_s  = a_mag_s % divisor_s;
        prod_s     = (a_neg_s ^ b_neg_s) ? (~prod_mag_s + 64'd1) : prod_mag_s;
        quot_s     = (a_neg_s ^ b_neg_s) ? md_neg32(quot_mag_s) : quot_mag_s;
        rem_s      = a_neg_s ? md_neg32(rem_mag_s) : rem_mag_s;
    end

    // Result select by operation.
    always_comb begin
        result   = 64'd0;
        div_zero = 1'b0;
        case (md_op)
            MD_MULT, MD_MULTU: begin
                result = prod_s;
            end
            MD_DIV, MD_DIVU: begin
                result   = {rem_s, quot_s};
                div_zero = (rt_val == 32'd0);
            end
            default: begin
                result   = 64'd0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit_chk.sv
// md_unit_chk: protocol monitor for md_unit.
//   clk, reset in : same clock / async active-low reset as md_unit
//   start, busy in: request strobe and busy flag of md_unit
//   violation out : sticky flag, set when start arrives while busy is high
// A request while busy is dropped by md_unit; the hazard unit is supposed to
// stall instead, so any occurrence is a pipeline control bug upstream.
module md_unit_chk (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    output logic violation
);

    logic violation_q;
    logic violation_d;

    // Next value of the sticky violation flag.
    always_comb begin
        if (start && busy) begin
            violation_d = 1'b1;
        end else begin
            violation_d = violation_q;
        end
    end

    // Violation flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            violation_q <= 1'b0;
        end else begin
            violation_q <= violation_d;
        end
    end

    assign violation = violation_q;

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit holding the HI/LO registers.
//   clk    in  : rising-edge clock
//   reset  in  : asynchronous active-low reset
//   start  in  : one-cycle request strobe
//   md_op  in  : operation (md_defs encodings)
//   rs_val in  : forwarded rs operand
//   rt_val in  : forwarded rt operand
//   busy   out : result in flight; HI/LO not yet updated
//   hi     out : HI register
//   lo     out : LO register
// The result is computed in the request cycle and parked in pend_hi/pend_lo;
// the counter only models the architectural latency. HI/LO keep their old
// values until the commit edge, so readers must stall on busy.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [0:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             busy_q,     busy_d;
    logic [31:0]      hi_q,       hi_d;
    logic [31:0]      lo_q,       lo_d;
    logic [31:0]      pend_hi_q,  pend_hi_d;
    logic [31:0]      pend_lo_q,  pend_lo_d;
    // Cleared for divide-by-zero so the commit edge leaves HI/LO untouched.
    logic             pend_ok_q,  pend_ok_d;

    logic [63:0]      calc_res_s;
    logic             calc_div_zero_s;

    md_calc u_calc (
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .result   (calc_res_s),
        .div_zero (calc_div_zero_s)
    );

    // Control FSM, latency counter and HI/LO next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            pend_hi_d = calc_res_s[63:32];
                            pend_lo_d = calc_res_s[31:0];
                            pend_ok_d = 1'b1;
                            cnt_d     = MULT_CNT;
                            busy_d    = 1'b1;
                            state_d   = MD_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_hi_d = calc_res_s[63:32];
                            pend_lo_d = calc_res_s[31:0];
                            pend_ok_d = ~calc_div_zero_s;
                            cnt_d     = DIV_CNT;
                            busy_d    = 1'b1;
                            state_d   = MD_RUN;
                        end
                        MD_MTHI: begin
                            hi_d = rs_val;
                        end
                        MD_MTLO: begin
                            lo_d = rs_val;
                        end
                        default: begin
                            state_d = MD_IDLE;
                        end
                    endcase
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_RUN: begin
                // Requests arriving here are dropped on purpose.
                if (cnt_q == CNT_ONE) begin
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b0;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = CNT_ZERO;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter, HI/LO and pending-result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= CNT_ZERO;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit of the E stage; producer of the HI/LO values that the later pipeline registers carry down to W.
- Accepts one mult/div/mthi/mtlo request per start pulse from the E-stage decoder.
- Holds HI/LO architectural state and models fixed multi-cycle latency.
- Exposes busy to the hazard unit, which stalls any later md instruction or mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (>=1)
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request strobe from E stage
- md_op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- busy  output  1  operation in flight; HI/LO not yet valid
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset low, async): state IDLE, counter 0, busy 0, hi 0, lo 0, pending regs 0. Takes effect immediately, mid-operation included; the in-flight result is discarded.
- FSM states: IDLE, RUN.
- IDLE with start=1 and md_op in {MULT, MULTU}:
  - compute the 64-bit product of rs_val and rt_val (signed/unsigned per op) into pend_hi/pend_lo;
  - load counter with MULT_CYCLES;
  - go to RUN; busy=1 from the next cycle.
- IDLE with start=1 and md_op in {DIV, DIVU}:
  - pend_lo = quotient, pend_hi = remainder;
  - signed division truncates toward zero; remainder takes the sign of the dividend;
  - load counter with DIV_CYCLES; go to RUN.
- Divide by zero (rt_val==0):
  - still enters RUN for DIV_CYCLES;
  - on completion hi/lo keep their prior values; pend regs are not committed.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
- IDLE with start=1 and MTHI: hi <= rs_val at that edge; lo unchanged; busy stays 0. MTLO is the same for lo.
- start=1 with md_op NONE or reserved: no effect.
- RUN:
  - counter decrements each cycle;
  - on the cycle the counter reaches 1, the next edge commits pend_hi/pend_lo to hi/lo, clears busy, and returns to IDLE;
  - the new hi/lo and busy=0 are visible in the same cycle.
  - Latency: start at edge k -> busy high for edges k+1..k+N -> hi/lo updated at edge k+N.
- start while busy (any op): ignored, with no state change. The hazard unit guarantees this does not occur; an SVA-style check flags it.
- hi/lo hold their value during RUN, so mfhi/mflo issued during RUN reads stale values; stalling on busy is the hazard unit's duty.
- Width rules: all products and quotients are computed at full 64/32 bits; no truncation except the hi/lo split at bit 32.

Decomposition:
- Shared package md_defs:
  - md_op encodings (MD_NONE..MD_MTLO);
  - state encoding (MD_IDLE, MD_RUN);
  - default cycle counts.
- One natural sub-module: md_calc. It is purely combinational: md_op, rs_val, rt_val in; 64-bit {hi,lo} result and a div_zero flag out.
- FSM, counter and HI/LO registers stay in md_unit.

Test Plan:
- Reset release, then MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIVU 7/0 with prior hi=0x11, lo=0x22 -> busy 10 cycles; hi/lo stay 0x11/0x22.
- MTHI rs=0xDEADBEEF, then MTLO rs=0x12345678 on consecutive cycles -> busy never asserts; hi/lo update at each edge.
- Start DIV, then drive start with MULT on cycle 3 of RUN -> ignored; DIV result committed at cycle 10.
- Assert reset low mid-DIV at cycle 4, asynchronously between edges -> busy, hi and lo go to 0 immediately. After release, IDLE accepts a new MULT.
